// File: rtl/sobel_seq_pkg.sv
// Shared types and constants for the Sobel window sequencer.
// Holds the FSM state encoding, pixel width and the window-slot indices
// that map x_1..x_6 onto the window register array.
package sobel_seq_pkg;

  localparam int PIX_W     = 8;
  localparam int NUM_SLOTS = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Window slots: top row (r-1, c-1..c+1) then bottom row (r+1, c-1..c+1).
  localparam logic [2:0] SLOT_X1 = 3'd0;
  localparam logic [2:0] SLOT_X2 = 3'd1;
  localparam logic [2:0] SLOT_X3 = 3'd2;
  localparam logic [2:0] SLOT_X4 = 3'd3;
  localparam logic [2:0] SLOT_X5 = 3'd4;
  localparam logic [2:0] SLOT_X6 = 3'd5;

  // Reads issued per window: all six at the start of a row, only the new
  // right-hand column (x_3, x_6) while sliding along the row.
  localparam logic [2:0] FULL_READS  = 3'd6;
  localparam logic [2:0] SLIDE_READS = 3'd2;

  // Slot targeted by the k-th read of a window fetch.
  function automatic logic [2:0] fetch_slot(input logic full, input logic [2:0] k);
    if (full) begin
      return k;
    end
    return (k == 3'd0) ? SLOT_X3 : SLOT_X6;
  endfunction

endpackage

// File: rtl/sobel_seq_addr_gen.sv
// Window position tracker for the Sobel sequencer.
// Keeps the interior window position (r, c), the pixel address of the window
// centre (r*COLS + c) and the edge-memory index (r-1)*(COLS-2)+(c-1), all
// updated incrementally so no multiplier is needed. Produces the pixel
// address of any window slot plus first/last-column and last-window flags.
module sobel_seq_addr_gen
  import sobel_seq_pkg::*;
#(
  parameter int ROWS   = 436,
  parameter int COLS   = 576,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [2:0]        slot_i,
  output logic              first_col_o,
  output logic              last_col_o,
  output logic              last_win_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [ADDR_W-1:0] edge_addr_o
);

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] THREE   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(COLS - 2);
  localparam logic [ADDR_W-1:0] LAST_R  = ADDR_W'(ROWS - 2);
  localparam logic [ADDR_W-1:0] CTR0    = ADDR_W'(COLS + 1);
  localparam logic [ADDR_W-1:0] OFS_C   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] OFS_CP1 = ADDR_W'(COLS + 1);
  localparam logic [ADDR_W-1:0] OFS_CM1 = ADDR_W'(COLS - 1);

  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] ctr_q, ctr_d;
  logic [ADDR_W-1:0] eidx_q, eidx_d;

  assign first_col_o = (c_q == ONE);
  assign last_col_o  = (c_q == LAST_C);
  assign last_win_o  = (r_q == LAST_R) && (c_q == LAST_C);
  assign edge_addr_o = eidx_q;

  // Next position: restart at (1,1) on a new frame, otherwise step raster-order.
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    ctr_d  = ctr_q;
    eidx_d = eidx_q;
    if (clear_i) begin
      r_d    = ONE;
      c_d    = ONE;
      ctr_d  = CTR0;
      eidx_d = '0;
    end else if (advance_i) begin
      eidx_d = eidx_q + ONE;
      if (last_col_o) begin
        // (r, COLS-2) -> (r+1, 1): centre address moves by exactly 3.
        r_d   = r_q + ONE;
        c_d   = ONE;
        ctr_d = ctr_q + THREE;
      end else begin
        c_d   = c_q + ONE;
        ctr_d = ctr_q + ONE;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= ONE;
      c_q    <= ONE;
      ctr_q  <= CTR0;
      eidx_q <= '0;
    end else begin
      r_q    <= r_d;
      c_q    <= c_d;
      ctr_q  <= ctr_d;
      eidx_q <= eidx_d;
    end
  end

  // Slot address relative to the window centre.
  always_comb begin
    case (slot_i)
      SLOT_X2: pix_addr_o = ctr_q - OFS_C;
      SLOT_X3: pix_addr_o = ctr_q - OFS_CM1;
      SLOT_X4: pix_addr_o = ctr_q + OFS_CM1;
      SLOT_X5: pix_addr_o = ctr_q + OFS_C;
      SLOT_X6: pix_addr_o = ctr_q + OFS_CP1;
      default: pix_addr_o = ctr_q - OFS_CP1;
    endcase
  end

endmodule

// File: rtl/sobel_window_sequencer.sv
// Frame-level controller for the 8-bit stochastic Sobel datapath.
// Walks every interior 3x3 window of a ROWS x COLS image, fetches the six
// non-centre-row neighbours (reusing two columns while sliding along a row),
// runs the datapath through a start/done handshake and writes each result to
// the edge memory while tracking the frame maximum.
//
// Handshake: dp_start is a one-cycle pulse; x_*_bin are stable from that
// cycle until the result is taken. dp_done is a one-cycle pulse honoured only
// while waiting, with z_bin valid in the same cycle. src_data is valid the
// cycle after src_rd. Everything else is registered.
//
// Build option SOBEL_SEQ_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT cycles
// that writes a zero edge and sets the sticky err_timeout flag. Without it
// WAIT is unbounded and err_timeout is tied low.
module sobel_window_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int ROWS    = 436,
  parameter int COLS    = 576,
  parameter int ADDR_W  = 18,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic [PIX_W-1:0]  x_1_bin,
  output logic [PIX_W-1:0]  x_2_bin,
  output logic [PIX_W-1:0]  x_3_bin,
  output logic [PIX_W-1:0]  x_4_bin,
  output logic [PIX_W-1:0]  x_5_bin,
  output logic [PIX_W-1:0]  x_6_bin,
  output logic              dp_start,
  input  logic              dp_done,
  input  logic [PIX_W-1:0]  z_bin,
  output logic              edge_we,
  output logic [ADDR_W-1:0] edge_addr,
  output logic [PIX_W-1:0]  edge_data,
  output logic [PIX_W-1:0]  max_val,
  output logic              err_timeout,
  output state_t            dbg_state_o
);

  state_t           state_q;
  logic [2:0]       fcnt_q;
  logic [PIX_W-1:0] x_q [NUM_SLOTS];
  logic             busy_q;
  logic             frame_done_q;
  logic             dp_start_q;
  logic             edge_we_q;
  logic [PIX_W-1:0] edge_data_q;
  logic [PIX_W-1:0] max_val_q;

`ifdef SOBEL_SEQ_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  logic [WCNT_W-1:0] wcnt_q;
  logic              err_q;
`endif

  logic              first_col;
  logic              last_col;
  logic              last_win;
  logic [2:0]        n_reads;
  logic              rd_active;
  logic [2:0]        rd_slot;
  logic [2:0]        cap_slot;
  logic              gen_clear;
  logic              gen_advance;
  logic [ADDR_W-1:0] pix_addr;

  assign n_reads     = first_col ? FULL_READS : SLIDE_READS;
  assign rd_active   = (state_q == ST_FETCH) && (fcnt_q < n_reads);
  assign rd_slot     = fetch_slot(first_col, fcnt_q);
  // Data returned this cycle belongs to the read issued one cycle earlier.
  assign cap_slot    = fetch_slot(first_col, fcnt_q - 3'd1);
  assign gen_clear   = (state_q == ST_IDLE) && frame_start;
  assign gen_advance = (state_q == ST_WRITE);

  sobel_seq_addr_gen #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (gen_clear),
    .advance_i   (gen_advance),
    .slot_i      (rd_slot),
    .first_col_o (first_col),
    .last_col_o  (last_col),
    .last_win_o  (last_win),
    .pix_addr_o  (pix_addr),
    .edge_addr_o (edge_addr)
  );

  // Address bus is held at zero when no read is in flight.
  assign src_rd      = rd_active;
  assign src_addr    = rd_active ? pix_addr : '0;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign dp_start    = dp_start_q;
  assign edge_we     = edge_we_q;
  assign edge_data   = edge_data_q;
  assign max_val     = max_val_q;
  assign x_1_bin     = x_q[SLOT_X1];
  assign x_2_bin     = x_q[SLOT_X2];
  assign x_3_bin     = x_q[SLOT_X3];
  assign x_4_bin     = x_q[SLOT_X4];
  assign x_5_bin     = x_q[SLOT_X5];
  assign x_6_bin     = x_q[SLOT_X6];
  assign dbg_state_o = state_q;
`ifdef SOBEL_SEQ_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Sequencer FSM with window registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dp_start_q   <= 1'b0;
      edge_we_q    <= 1'b0;
      edge_data_q  <= '0;
      max_val_q    <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        x_q[s] <= '0;
      end
`ifdef SOBEL_SEQ_TIMEOUT_EN
      wcnt_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      dp_start_q   <= 1'b0;
      edge_we_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            busy_q    <= 1'b1;
            max_val_q <= '0;
            fcnt_q    <= '0;
`ifdef SOBEL_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Sliding along a row: the two left columns come from the old window.
          if (!first_col && (fcnt_q == 3'd0)) begin
            x_q[SLOT_X1] <= x_q[SLOT_X2];
            x_q[SLOT_X2] <= x_q[SLOT_X3];
            x_q[SLOT_X4] <= x_q[SLOT_X5];
            x_q[SLOT_X5] <= x_q[SLOT_X6];
          end
          if (fcnt_q != 3'd0) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              if (cap_slot == 3'(s)) begin
                x_q[s] <= src_data;
              end
            end
          end
          if (fcnt_q == n_reads) begin
            fcnt_q     <= '0;
            dp_start_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end else begin
            fcnt_q <= fcnt_q + 3'd1;
          end
        end
        ST_ISSUE: begin
`ifdef SOBEL_SEQ_TIMEOUT_EN
          wcnt_q  <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result in the same cycle as the watchdog expiry takes priority.
          if (dp_done) begin
            edge_data_q <= z_bin;
            edge_we_q   <= 1'b1;
            state_q     <= ST_WRITE;
          end
`ifdef SOBEL_SEQ_TIMEOUT_EN
          else if (wcnt_q == WCNT_LAST) begin
            edge_data_q <= '0;
            edge_we_q   <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= ST_WRITE;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
        end
        ST_WRITE: begin
          if (edge_data_q > max_val_q) begin
            max_val_q <= edge_data_q;
          end
          if (last_win) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            fcnt_q  <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // last_col is consumed inside the position tracker; kept visible here for probing.
  logic unused_last_col;
  assign unused_last_col = last_col;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Self-checking bench for sobel_window_sequencer on a 4x5 image (src[k]=k).
// Frame scenarios come from a vector table; reset-abort is a hand sequence.
module tb_sobel_window_sequencer;
  import sobel_seq_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 5;
  localparam int ADDR_W = 18;
  localparam int NWIN   = (ROWS - 2) * (COLS - 2);
  localparam int NPIX   = ROWS * COLS;
`ifdef SOBEL_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  localparam int MODE_DIFF   = 0;
  localparam int MODE_SCRIPT = 1;
  localparam int MODE_NEVER  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              frame_start, busy, frame_done, src_rd;
  logic [ADDR_W-1:0] src_addr, edge_addr;
  logic [7:0]        src_data = '0;
  logic [7:0]        x_1_bin, x_2_bin, x_3_bin, x_4_bin, x_5_bin, x_6_bin;
  logic              dp_start, dp_done, edge_we, err_timeout;
  logic [7:0]        z_bin, edge_data, max_val;
  state_t            dbg_state;

  logic       fs_main = 1'b0, fs_noise = 1'b0;
  logic       dp_done_m = 1'b0, dp_done_n = 1'b0;
  logic [7:0] z_m = '0;
  assign frame_start = fs_main | fs_noise;
  assign dp_done     = dp_done_m | dp_done_n;
  assign z_bin       = dp_done_n ? 8'hEE : z_m;

  sobel_window_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .src_rd(src_rd), .src_addr(src_addr),
    .src_data(src_data), .x_1_bin(x_1_bin), .x_2_bin(x_2_bin),
    .x_3_bin(x_3_bin), .x_4_bin(x_4_bin), .x_5_bin(x_5_bin),
    .x_6_bin(x_6_bin), .dp_start(dp_start), .dp_done(dp_done),
    .z_bin(z_bin), .edge_we(edge_we), .edge_addr(edge_addr),
    .edge_data(edge_data), .max_val(max_val), .err_timeout(err_timeout),
    .dbg_state_o(dbg_state)
  );

  // ---------------- checking infrastructure ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [7:0] mem [0:NPIX-1];

  function automatic logic [47:0] win_exp(input int i);
    int r, c, b0, b2;
    r  = 1 + i / (COLS - 2);
    c  = 1 + i % (COLS - 2);
    b0 = (r - 1) * COLS + c - 1;
    b2 = (r + 1) * COLS + c - 1;
    return {mem[b0], mem[b0+1], mem[b0+2], mem[b2], mem[b2+1], mem[b2+2]};
  endfunction

  function automatic logic [5:0][7:0] mk6(input logic [7:0] a0, a1, a2, a3, a4, a5);
    logic [5:0][7:0] v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4; v[5] = a5;
    return v;
  endfunction

  // ---------------- synchronous-read pixel memory ----------------
  always @(posedge clk) begin
    if (src_rd) src_data <= (src_addr < ADDR_W'(NPIX)) ? mem[src_addr[4:0]] : 8'hEE;
  end

  // ---------------- datapath model ----------------
  int              mode = MODE_DIFF;
  logic [5:0][7:0] script = '0;
  int              clr_req = 0;
  int              m_ack = 0;
  int              m_idx = 0;
  int              cd = 0;
  logic [7:0]      z_pend = '0;

  always @(negedge clk) begin
    dp_done_m = 1'b0;
    if (clr_req != m_ack) begin
      m_idx = 0;
      m_ack = clr_req;
    end
    if (!reset) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dp_done_m = 1'b1;
          z_m       = z_pend;
        end
      end
      if (dp_start) begin
        if (mode == MODE_DIFF) z_pend = x_6_bin - x_1_bin;
        else if (m_idx < 6)    z_pend = script[m_idx];
        else                   z_pend = 8'h00;
        m_idx++;
        if (mode != MODE_NEVER) cd = 5;
      end
    end
  end

  // ---------------- noise: stray frame_start / dp_done ----------------
  logic noise_en = 1'b0;
  always @(negedge clk) begin
    dp_done_n = 1'b0;
    fs_noise  = 1'b0;
    if (noise_en && reset) begin
      if (dbg_state == ST_FETCH) dp_done_n = 1'b1;
      if (dbg_state == ST_WAIT)  fs_noise  = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [ADDR_W+7:0] exp_q[$];
  int clr_ack = 0;
  int rd_cnt = 0, rd_since = 0, dps_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int cyc = 0, dps_cyc = 0, exp_gap = 6;

  always @(negedge clk) begin
    logic [ADDR_W+7:0] e;
    if (clr_req != clr_ack) begin
      rd_cnt = 0; rd_since = 0; dps_cnt = 0; wr_cnt = 0; done_cnt = 0;
      clr_ack = clr_req;
    end
    if (reset) begin
      cyc++;
      if (src_rd) begin
        rd_cnt++;
        rd_since++;
      end
      if (dp_start) begin
        if (dps_cnt < NWIN) begin
          check("window", {x_1_bin, x_2_bin, x_3_bin, x_4_bin, x_5_bin, x_6_bin}, win_exp(dps_cnt));
          check("reads_per_window", rd_since, (dps_cnt % (COLS - 2) == 0) ? 6 : 2);
        end else begin
          check("dp_start_count", dps_cnt, NWIN - 1);
        end
        dps_cnt++;
        rd_since = 0;
        dps_cyc  = cyc;
      end
      if (edge_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL edge_write: unexpected write addr=%0d data=%0d", edge_addr, edge_data);
        end else begin
          e = exp_q.pop_front();
          check("edge_write", {edge_addr, edge_data}, e);
        end
        check("write_latency", cyc - dps_cyc, exp_gap);
      end
      if (frame_done) done_cnt++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int              mode;
    logic            noise;
    logic [5:0][7:0] script;
    logic [5:0][7:0] exp_data;
    logic [7:0]      exp_max;
    int              exp_rd;
    int              exp_dps;
    int              exp_gap;
    logic            exp_err;
  } vec_t;

  vec_t vecs [4];
  int   nv;

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check("frame_done_seen", done_cnt != 0, 1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v        = vecs[i];
    mode     = v.mode;
    script   = v.script;
    exp_gap  = v.exp_gap;
    exp_q.delete();
    for (int k = 0; k < NWIN; k++) exp_q.push_back({ADDR_W'(k), v.exp_data[k]});
    clr_req++;
    @(negedge clk);
    noise_en = v.noise;
    fs_main  = 1'b1;
    @(negedge clk);
    fs_main  = 1'b0;
    check("max_cleared_on_start", max_val, 8'd0);
    check("busy_on_start", busy, 1'b1);
    wait_done(3000);
    @(negedge clk);
    noise_en = 1'b0;
    check("frame_done_count", done_cnt, 1);
    check("busy_after_done", busy, 1'b0);
    check("state_after_done", dbg_state, ST_IDLE);
    check("write_count", wr_cnt, NWIN);
    check("writes_outstanding", exp_q.size(), 0);
    check("src_rd_count", rd_cnt, v.exp_rd);
    check("dp_start_count", dps_cnt, v.exp_dps);
    check("max_val", max_val, v.exp_max);
    check("err_timeout", err_timeout, v.exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {busy, frame_done, src_rd, dp_start, edge_we, err_timeout}, '0);
    check({tag, "_addr"}, {src_addr, edge_addr}, '0);
    check({tag, "_window"}, {x_1_bin, x_2_bin, x_3_bin, x_4_bin, x_5_bin, x_6_bin}, '0);
    check({tag, "_data"}, {edge_data, max_val}, '0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < NPIX; k++) mem[k] = 8'(k);

    vecs[0] = '{MODE_DIFF, 1'b0, '0, mk6(12, 12, 12, 12, 12, 12), 8'd12, 20, 6, 6, 1'b0};
    vecs[1] = '{MODE_SCRIPT, 1'b0, mk6(7, 200, 3, 255, 9, 1),
                mk6(7, 200, 3, 255, 9, 1), 8'd255, 20, 6, 6, 1'b0};
    vecs[2] = '{MODE_DIFF, 1'b1, '0, mk6(12, 12, 12, 12, 12, 12), 8'd12, 20, 6, 6, 1'b0};
    vecs[3] = '{MODE_NEVER, 1'b0, '0, mk6(0, 0, 0, 0, 0, 0), 8'd0, 20, 6, TMO + 1, 1'b1};
`ifdef SOBEL_SEQ_TIMEOUT_EN
    nv = 4;
`else
    nv = 3;
`endif

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < nv; i++) run_vec(i);

    // Reset asserted while waiting on the third window abandons the frame.
    mode    = MODE_DIFF;
    exp_gap = 6;
    exp_q.delete();
    for (int k = 0; k < NWIN; k++) exp_q.push_back({ADDR_W'(k), 8'd12});
    clr_req++;
    @(negedge clk);
    fs_main = 1'b1;
    @(negedge clk);
    fs_main = 1'b0;
    for (int i = 0; i < 1000 && dps_cnt < 3; i++) @(negedge clk);
    check("abort_reached_window3", dps_cnt, 3);
    repeat (2) @(negedge clk);
    check("abort_in_wait", dbg_state, ST_WAIT);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
